pa_pg_after_timing_adapter: RTL and testbench
=============================================

Name: pa_pg_after_timing_adapter

Overview:
- Avalon-ST timing adapter that sits after the packet analyser/generator, on the return side of the 10G example datapath.
- Accepts a stream from a source with ready latency READY_LATENCY (valid may follow ready by up to READY_LATENCY cycles) and re-times it onto a readyLatency=0 valid/ready sink.
- A small first-word-fall-through FIFO absorbs the latency window and downstream backpressure.
- Protocol violations and overflow are flagged, not silently ignored.

Parameters:
DATA_W, 2, payload width in bits
DEPTH, 4, FIFO entries; must be a power of 2 and >= READY_LATENCY+1
READY_LATENCY, 1, upstream ready-to-valid latency in cycles; legal range 0..3
CNT_W, 16, width of drop counter

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  synchronous reset, active-low
in_data  in  DATA_W  upstream payload
in_valid  in  1  upstream beat valid
in_ready  out  1  registered ready to upstream, honoured with READY_LATENCY
out_data  out  DATA_W  FIFO head payload
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream ready, latency 0
fill_level  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a beat was dropped
drop_count  out  CNT_W  dropped beats, saturating

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clk, reset_n).
- Reset (reset_n=0 sampled at a clk edge):
  - occupancy=0, pointers=0, in_ready=0, ready history=0.
  - out_valid=0, overflow=0, drop_count=0.
  - out_data is don't-care while out_valid=0.
  - Reset mid-stream discards all FIFO contents and in-flight credits.
- Pop: occurs when out_valid && out_ready.
  - out_data always shows the head entry.
  - A write into an empty FIFO is visible on out_valid/out_data the next cycle (1-cycle fall-through latency).
- Push:
  - in_valid=1 with occupancy<DEPTH → write.
  - in_valid=1 with occupancy==DEPTH and a pop in the same cycle → write (simultaneous push/pop at full is legal).
  - in_valid=1 with occupancy==DEPTH and no pop → drop the beat, set overflow, increment drop_count (saturates at all-ones).
- Occupancy update: occupancy_next = occupancy + push − pop. Pointers wrap modulo DEPTH.
- in_ready generation:
  - rhist is a READY_LATENCY-bit shift register of past in_ready values.
  - inflight = popcount(rhist).
  - in_ready_next = (occupancy_next + inflight_next) < DEPTH, where inflight_next counts grants still able to arrive after this cycle.
  - in_ready is registered.
  - With READY_LATENCY=0: in_ready_next = occupancy_next < DEPTH − 1 OR a pop is guaranteed. Simplification: use occupancy_next < DEPTH.
  - This guarantees a compliant source never overflows.
- in_valid outside a granted window: the beat is still accepted if space exists. No flag is raised.
- fill_level equals occupancy, registered.
- No combinational path from out_ready to in_ready.

Test Plan:
- Reset, then in_valid=1 with constant data 2'b10 and out_ready=1 → in_ready=1 one cycle after reset release; out_valid rises 1 cycle after the first write; every beat passes in order; fill_level≤1; overflow=0.
- out_ready=0, source honours in_ready with READY_LATENCY=1 → in_ready falls once occupancy+inflight reaches 4; exactly 4 beats stored; overflow=0; after out_ready=1 the data drains as 0,1,2,3.
- Source ignores in_ready and sends 6 beats while out_ready=0 → 4 stored, overflow=1, drop_count=2, out_data sequence is the first 4 beats.
- FIFO full (4), in_valid=1 and out_ready=1 in the same cycle → push and pop both occur, fill_level stays 4, no drop.
- Assert reset_n=0 for 1 cycle with 3 entries held → next cycle out_valid=0, fill_level=0, overflow=0, drop_count=0, in_ready=0, then in_ready=1 the following cycle.
- Drop-counter saturation with CNT_W=4: force 20 drops → drop_count holds 15.

Source files
------------

// File: rtl/pa_pg_after_timing_adapter.sv
// Avalon-ST timing adapter: re-times a ready-latency-N source onto a ready-latency-0 sink
// through a small first-word-fall-through FIFO with overflow detection.
module pa_pg_after_timing_adapter #(
  parameter int DATA_W        = 2,
  parameter int DEPTH         = 4,
  parameter int READY_LATENCY = 1,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int SW = OW + 2;
  localparam logic [OW-1:0] DEPTH_L = OW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || READY_LATENCY < 0 ||
      READY_LATENCY > 3 || DEPTH < READY_LATENCY + 1) begin : g_param_check
    $error("pa_pg_after_timing_adapter: illegal DEPTH/READY_LATENCY combination");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              in_ready_q, in_ready_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [SW-1:0]     inflight_d;
  logic              push, pop, drop;

  // Grants still able to deliver a beat after this cycle: the grant issued now plus
  // every older grant except the one whose latency window closes this cycle.
  if (READY_LATENCY > 0) begin : g_rhist
    logic [READY_LATENCY-1:0] rhist_q, rhist_d;

    always_comb begin
      rhist_d    = (rhist_q << 1) | READY_LATENCY'(in_ready_q);
      inflight_d = SW'(in_ready_q);
      for (int i = 0; i < READY_LATENCY; i++) begin
        inflight_d = inflight_d + SW'(rhist_q[i]);
      end
      inflight_d = inflight_d - SW'(rhist_q[READY_LATENCY-1]);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) rhist_q <= '0;
      else          rhist_q <= rhist_d;
    end
  end else begin : g_no_rhist
    assign inflight_d = '0;
  end

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    pop        = (occ_q != '0) && out_ready;
    push       = in_valid && ((occ_q < DEPTH_L) || pop);
    drop       = in_valid && !push;
    occ_d      = occ_q + OW'(push) - OW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    in_ready_d = (SW'(occ_d) + inflight_d) < SW'(DEPTH);
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: payload storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready   = in_ready_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (occ_q != '0);
  assign fill_level = occ_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_pa_pg_after_timing_adapter.sv
// Scoreboard bench: a transaction-level FIFO model predicts every output; a monitor
// compares DUT outputs on the falling edge and pops expected payloads on each transfer.
module tb_pa_pg_after_timing_adapter;

  localparam int DATA_W = 2;
  localparam int DEPTH  = 4;
  localparam int RL     = 1;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;

  logic              clk;
  logic              reset_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              out_ready;

  logic              in_ready, out_valid, overflow;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        fill_level;
  logic [CNT_W-1:0]  drop_count;

  logic              sat_in_ready, sat_out_valid, sat_overflow;
  logic [DATA_W-1:0] sat_out_data;
  logic [2:0]        sat_fill_level;
  logic [SAT_W-1:0]  sat_drop_count;

  pa_pg_after_timing_adapter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .READY_LATENCY(RL), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count));

  pa_pg_after_timing_adapter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .READY_LATENCY(RL), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(sat_in_ready),
    .out_data(sat_out_data), .out_valid(sat_out_valid), .out_ready(out_ready),
    .fill_level(sat_fill_level), .overflow(sat_overflow), .drop_count(sat_drop_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state describing the DUT right now (exp_*) and after the coming edge (nxt_*).
  int  exp_occ, exp_drops, nxt_occ, nxt_drops;
  bit  exp_ovf, exp_rdy, nxt_ovf, nxt_rdy;
  bit  exp_grants [RL];
  bit  nxt_grants [RL];
  logic [DATA_W-1:0] sb [$];
  int  n_vec, n_err;
  bit  mon_en;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sat_cnt(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("fill_level", int'(fill_level), exp_occ);
      check("out_valid", int'(out_valid), int'(exp_occ != 0));
      check("in_ready", int'(in_ready), int'(exp_rdy));
      check("overflow", int'(overflow), int'(exp_ovf));
      check("drop_count", int'(drop_count), sat_cnt(exp_drops, CNT_W));
      check("sat_drop_count", int'(sat_drop_count), sat_cnt(exp_drops, SAT_W));
      check("sat_fill_level", int'(sat_fill_level), exp_occ);
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out_valid", int'(out_valid), 0);
        else begin
          logic [DATA_W-1:0] e;
          e = sb.pop_front();
          check("out_data", int'(out_data), int'(e));
        end
      end
    end
  end

  // One clock cycle of stimulus; predicts the state after the edge from the spec rules.
  task automatic step(input bit rst, input bit v, input logic [DATA_W-1:0] d, input bit r);
    bit pop, push, drop;
    int open;
    exp_occ = nxt_occ; exp_drops = nxt_drops; exp_ovf = nxt_ovf; exp_rdy = nxt_rdy;
    exp_grants = nxt_grants;
    reset_n = !rst; in_valid = v; in_data = d; out_ready = r;
    if (rst) begin
      nxt_occ = 0; nxt_drops = 0; nxt_ovf = 0; nxt_rdy = 0;
      foreach (nxt_grants[i]) nxt_grants[i] = 0;
      sb.delete();
    end else begin
      pop  = (exp_occ > 0) && r;
      push = v && ((exp_occ < DEPTH) || pop);
      drop = v && !push;
      if (push) sb.push_back(d);
      nxt_occ   = exp_occ + int'(push) - int'(pop);
      nxt_drops = exp_drops + int'(drop);
      nxt_ovf   = exp_ovf | drop;
      // grant windows still open after this edge: this cycle's grant and all younger ones
      nxt_grants[0] = exp_rdy;
      for (int i = 1; i < RL; i++) nxt_grants[i] = exp_grants[i-1];
      open = 0;
      foreach (nxt_grants[i]) open += int'(nxt_grants[i]);
      nxt_rdy = (nxt_occ + open) < DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit prev_rdy;
    int sent;
    n_vec = 0; n_err = 0; mon_en = 0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    nxt_occ = 0; nxt_drops = 0; nxt_ovf = 0; nxt_rdy = 0;
    foreach (nxt_grants[i]) nxt_grants[i] = 0;

    step(1, 0, 0, 0);
    mon_en = 1;
    step(1, 0, 0, 0);

    // Streaming pass-through with constant data
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 2'b10, 1);
      check("stream_fill_le1", int'(fill_level <= 3'd1), 1);
    end

    // Compliant source, stalled sink, then drain
    step(1, 0, 0, 0);
    prev_rdy = 0; sent = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, prev_rdy, DATA_W'(sent), 0);
      if (prev_rdy) sent++;
      prev_rdy = in_ready;
    end
    check("honour_fill", int'(fill_level), 4);
    check("honour_ovf", int'(overflow), 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // Non-compliant source: 6 beats into a stalled sink
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, DATA_W'(i), 0);
    check("viol_drops", int'(drop_count), 2);
    check("viol_ovf", int'(overflow), 1);

    // Push and pop together while full
    for (int i = 0; i < 3; i++) step(0, 1, DATA_W'(i + 1), 1);
    check("full_pushpop_fill", int'(fill_level), 4);
    check("full_pushpop_drops", int'(drop_count), 2);

    // Saturation of the narrow counter
    for (int i = 0; i < 20; i++) step(0, 1, DATA_W'(i), 0);
    check("sat_hold", int'(sat_drop_count), 15);
    check("wide_count", int'(drop_count), 22);

    // Mid-stream reset with three entries held
    step(0, 0, 0, 1);
    check("pre_reset_fill", int'(fill_level), 3);
    step(1, 0, 0, 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    step(0, 0, 0, 0);
    check("post_rst_in_ready", int'(in_ready), 1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
           DATA_W'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    check("final_empty", int'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
